// File: rtl/param_rounder.sv
// Two-stage valid/ready pipeline that rounds away the low DROP bits of an unsigned
// operand using one of four rounding modes, with wrap or saturate on overflow.
module param_rounder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DROP  = 1,
  parameter int unsigned SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [7:0]       ovf_count
);

  localparam int unsigned HW = WIDTH - DROP;

  logic             s1_valid_q, s1_valid_d;
  logic [HW-1:0]    s1_hi_q, s1_hi_d;
  logic             s1_inc_q, s1_inc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;
  logic [7:0]       ovf_count_q, ovf_count_d;

  logic [DROP-1:0]  lo;
  logic [DROP-1:0]  half_lo;
  logic [HW-1:0]    hi;
  logic             inc;
  logic [HW:0]      sum;
  logic             ovf;
  logic [HW-1:0]    res_hi;
  logic             s2_adv;

  // Increment decision is made at acceptance so in_mode is sampled per item.
  always_comb begin
    lo      = in_data[DROP-1:0];
    hi      = in_data[WIDTH-1:DROP];
    half_lo = '0;
    half_lo[DROP-1] = 1'b1;
    case (in_mode)
      2'b00:   inc = 1'b0;
      2'b01:   inc = (lo >= half_lo);
      2'b10:   inc = (lo > half_lo) || ((lo == half_lo) && hi[0]);
      default: inc = (lo != '0);
    endcase
  end

  always_comb begin
    sum    = {1'b0, s1_hi_q} + {{HW{1'b0}}, s1_inc_q};
    ovf    = sum[HW];
    res_hi = (ovf && (SAT != 0)) ? {HW{1'b1}} : sum[HW-1:0];
  end

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_hi_d     = s1_hi_q;
    s1_inc_d    = s1_inc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    ovf_count_d = ovf_count_q;

    if (out_valid_q && out_ready && out_ovf_q && (ovf_count_q != 8'hFF)) begin
      ovf_count_d = ovf_count_q + 8'd1;
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      // Only load on a real item so the outputs stay quiet across bubbles.
      if (s1_valid_q) begin
        out_data_d = {res_hi, {DROP{1'b0}}};
        out_ovf_d  = ovf;
      end
    end

    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_hi_d  = hi;
        s1_inc_d = inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_hi_q     <= '0;
      s1_inc_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      ovf_count_q <= 8'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_hi_q     <= s1_hi_d;
      s1_inc_q    <= s1_inc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_param_rounder.sv
// Drives four param_rounder configurations in lockstep from one stimulus stream and checks
// each against an arithmetic reference model with a transaction queue.
module tb_param_rounder;

  typedef struct packed {
    logic [7:0]  data;
    logic [1:0]  mode;
    logic [31:0] acc;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       out_ready;

  logic       rdy0, rdy1, rdy2, rdy3;
  logic       ov0, ov1, ov2, ov3;
  logic [7:0] od0, od1, od2;
  logic [2:0] od3;
  logic       of0, of1, of2, of3;
  logic [7:0] oc0, oc1, oc2, oc3;

  logic       rdy [4];
  logic       ov  [4];
  logic [7:0] od  [4];
  logic       of  [4];
  logic [7:0] oc  [4];

  int         errors = 0;
  int         checks = 0;
  int         cnt [4];
  logic [31:0] cyc = 0;
  item_t      q [$];

  always #5 clk = ~clk;

  param_rounder #(.WIDTH(8), .DROP(1), .SAT(0)) u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_mode(in_mode), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .out_ovf(of0), .ovf_count(oc0));

  param_rounder #(.WIDTH(8), .DROP(2), .SAT(0)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_mode(in_mode), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .out_ovf(of1), .ovf_count(oc1));

  param_rounder #(.WIDTH(8), .DROP(1), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .in_mode(in_mode), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .out_ovf(of2), .ovf_count(oc2));

  param_rounder #(.WIDTH(3), .DROP(1), .SAT(0)) u_w3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .in_data(in_data[2:0]),
    .in_mode(in_mode), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
    .out_ovf(of3), .ovf_count(oc3));

  always_comb begin
    rdy[0] = rdy0; rdy[1] = rdy1; rdy[2] = rdy2; rdy[3] = rdy3;
    ov[0]  = ov0;  ov[1]  = ov1;  ov[2]  = ov2;  ov[3]  = ov3;
    od[0]  = od0;  od[1]  = od1;  od[2]  = od2;  od[3]  = {5'b0, od3};
    of[0]  = of0;  of[1]  = of1;  of[2]  = of2;  of[3]  = of3;
    oc[0]  = oc0;  oc[1]  = oc1;  oc[2]  = oc2;  oc[3]  = oc3;
  end

  // Reference: plain integer rounding of data to a multiple of 2^d within w bits.
  function automatic logic [8:0] ref_round(input int unsigned data, input int unsigned mode,
                                           input int unsigned w, input int unsigned d,
                                           input int unsigned s);
    int unsigned x, hi, lo, half, inc, sum, top, res;
    logic        ovf;
    x    = data % (1 << w);
    hi   = x >> d;
    lo   = x % (1 << d);
    half = 1 << (d - 1);
    case (mode)
      0:       inc = 0;
      1:       inc = (lo >= half) ? 1 : 0;
      2:       inc = ((lo > half) || (lo == half && (hi % 2) == 1)) ? 1 : 0;
      default: inc = (lo != 0) ? 1 : 0;
    endcase
    sum = hi + inc;
    top = 1 << (w - d);
    ovf = (sum >= top);
    if (ovf) res = (s != 0) ? top - 1 : sum - top;
    else     res = sum;
    return {ovf, 8'(res << d)};
  endfunction

  task automatic chk(input string tag, input int idx, input logic [7:0] obs,
                     input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, idx, cyc, obs, expv);
    end
  endtask

  // One cycle: drive at the falling edge, compare, then update the model for the next edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic [1:0] m,
                      input logic ordy);
    logic       exp_ov, exp_rdy;
    logic [8:0] r;
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    #1;
    exp_ov  = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
    exp_rdy = (q.size() < 2) || ordy;
    for (int i = 0; i < 4; i++) begin
      chk("out_valid", i, {7'b0, ov[i]}, {7'b0, exp_ov});
      chk("in_ready", i, {7'b0, rdy[i]}, {7'b0, exp_rdy});
      chk("ovf_count", i, oc[i], 8'(cnt[i]));
      if (exp_ov) begin
        r = ref_round(q[0].data, q[0].mode, (i == 3) ? 3 : 8, (i == 1) ? 2 : 1,
                      (i == 2) ? 1 : 0);
        chk("out_data", i, od[i], r[7:0]);
        chk("out_ovf", i, {7'b0, of[i]}, {7'b0, r[8]});
        if (ordy && r[8] && cnt[i] < 255) cnt[i]++;
      end
    end
    if (exp_ov && ordy) void'(q.pop_front());
    if (v && exp_rdy) q.push_back('{data: d, mode: m, acc: cyc});
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_mode   = 2'b00;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  initial begin
    do_reset();
    // Reset state, then single item with out_ready high.
    tick(1'b0, 8'h00, 2'b00, 1'b1);
    tick(1'b1, 8'h07, 2'b01, 1'b1);
    repeat (3) tick(1'b0, 8'h00, 2'b00, 1'b1);
    // Half-even sequence, back to back.
    tick(1'b1, 8'h06, 2'b10, 1'b1);
    tick(1'b1, 8'h0A, 2'b10, 1'b1);
    tick(1'b1, 8'h0B, 2'b10, 1'b1);
    repeat (3) tick(1'b0, 8'h00, 2'b00, 1'b1);
    // Overflow on the top code.
    tick(1'b1, 8'hFF, 2'b01, 1'b1);
    repeat (3) tick(1'b0, 8'h00, 2'b00, 1'b1);
    // Backpressure: two accepted, third refused until out_ready rises.
    tick(1'b1, 8'h01, 2'b11, 1'b0);
    tick(1'b1, 8'h03, 2'b11, 1'b0);
    repeat (4) tick(1'b1, 8'h05, 2'b11, 1'b0);
    tick(1'b1, 8'h05, 2'b11, 1'b1);
    repeat (4) tick(1'b0, 8'h00, 2'b00, 1'b1);
    // Random traffic with random backpressure.
    repeat (300) tick(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom),
                      ($urandom_range(0, 3) != 0));
    repeat (4) tick(1'b0, 8'h00, 2'b00, 1'b1);
    // Reset with two items in flight; neither may appear afterwards.
    tick(1'b1, 8'h11, 2'b01, 1'b0);
    tick(1'b1, 8'h22, 2'b11, 1'b0);
    tick(1'b0, 8'h00, 2'b00, 1'b0);
    do_reset();
    repeat (5) tick(1'b0, 8'h00, 2'b00, 1'b1);
    // Full 3-bit sweep in half-up mode.
    for (int i = 0; i < 8; i++) tick(1'b1, 8'(i), 2'b01, 1'b1);
    repeat (3) tick(1'b0, 8'h00, 2'b00, 1'b1);
    // Drive ovf_count into saturation.
    repeat (262) tick(1'b1, 8'hFF, 2'b01, 1'b1);
    repeat (4) tick(1'b0, 8'h00, 2'b00, 1'b1);
    repeat (150) tick(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom),
                      ($urandom_range(0, 1) != 0));
    repeat (4) tick(1'b0, 8'h00, 2'b00, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_rounder.md
PARAM_ROUNDER -- requirements
Module: param_rounder

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits; legal range 2..32.
REQ-002 Parameter DROP, default 1: number of LSBs rounded away; legal range 1..WIDTH-1.
REQ-003 Parameter SAT, default 0: overflow policy; 0 = wrap, 1 = saturate.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  in_data and in_mode are valid this cycle.
REQ-008 in_ready  out  1  block accepts input this cycle.
REQ-009 in_data  in  WIDTH  unsigned operand.
REQ-010 in_mode  in  2  rounding mode: 00 truncate, 01 half-up, 10 half-even, 11 ceiling.
REQ-011 out_valid  out  1  out_data and out_ovf are valid.
REQ-012 out_ready  in  1  downstream accepts output this cycle.
REQ-013 out_data  out  WIDTH  rounded result; the low DROP bits are always 0.
REQ-014 out_ovf  out  1  rounding overflowed for this result.
REQ-015 ovf_count  out  8  saturating count of transferred results with out_ovf=1.

Function
REQ-016 Definitions: lo = in_data[DROP-1:0]; hi = in_data[WIDTH-1:DROP]; half = 2^(DROP-1).
REQ-017 Increment inc is decided by in_mode as follows:
- 00: inc = 0.
- 01: inc = (lo >= half).
- 10: inc = (lo > half) or (lo == half and hi[0] == 1).
- 11: inc = (lo != 0).
REQ-018 sum = hi + inc, computed in WIDTH-DROP+1 bits; ovf = carry out of bit WIDTH-DROP-1.
REQ-019 Result = {sum[WIDTH-DROP-1:0], DROP zeros} when ovf=0, or when ovf=1 and SAT=0 (wrap).
REQ-020 Result = {all ones in WIDTH-DROP bits, DROP zeros} when ovf=1 and SAT=1.
REQ-021 Legacy equivalence: WIDTH=3, DROP=1, SAT=0, mode 01 maps inputs 0..7 to outputs 0,2,2,4,4,6,6,0.
REQ-022 Pipeline structure: two register stages.
- S1 captures in_data and in_mode and registers inc.
- S2 registers the result and ovf.
REQ-023 Each stage holds a valid bit and advances when it is empty or its downstream consumer takes its contents this cycle.
REQ-024 Input transfer occurs on in_valid && in_ready; output transfer occurs on out_valid && out_ready.
REQ-025 in_ready = !S1.valid || S1 advances this cycle; in_ready is combinational from out_ready, with no combinational path from in_valid.
REQ-026 Latency with out_ready held at 1: a result appears on out_valid exactly 2 cycles after input acceptance; throughput is 1 per cycle.
REQ-027 While out_valid=1 and out_ready=0:
- out_data, out_ovf and out_valid hold stable.
- The pipeline stores at most 2 items.
- in_ready=0 once both stages are full.
REQ-028 Order is preserved; no result is dropped or duplicated.
REQ-029 in_mode is sampled per item at acceptance; a mode change affects only items accepted afterwards.
REQ-030 Simultaneous input and output transfer in one cycle with both stages full is legal and keeps occupancy at 2.
REQ-031 ovf_count increments by 1 on each output transfer with out_ovf=1 and holds at 255.

Reset
REQ-032 While rst=1 at a clock edge, the following are cleared: out_valid=0, out_data=0, out_ovf=0, ovf_count=0, and both stage valid bits.
REQ-033 in_ready=1 in the first cycle after reset deasserts.
REQ-034 Reset mid-operation discards all in-flight items; no result for a pre-reset input appears after reset.

Verification
REQ-035 Default parameters, out_ready=1, mode 01, input 0x07 -> out_data 0x08, out_ovf 0, out_valid exactly 2 cycles after acceptance.
REQ-036 DROP=2, mode 10, inputs 0x06, 0x0A, 0x0B -> out_data 0x08, 0x08, 0x0C in order.
REQ-037 Mode 01, input 0xFF:
- SAT=0 -> out_data 0x00, out_ovf 1, ovf_count 1.
- SAT=1 -> out_data 0xFE, out_ovf 1.
REQ-038 out_ready=0; offer 0x01, 0x03, 0x05 back to back (mode 11):
- Only two are accepted; in_ready=0 on the third.
- First output 0x02 holds stable.
- After out_ready=1: outputs 0x02, 0x04, 0x06 in order.
REQ-039 Assert rst for one cycle with 2 items in flight -> out_valid=0 on the next cycle, ovf_count=0, and neither item is ever output.
REQ-040 WIDTH=3, DROP=1, SAT=0, mode 01, sweep inputs 0..7 -> outputs 0,2,2,4,4,6,6,0; out_ovf=1 only for input 7.
